uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Serial transmit back-end of the UART peripheral on the simple data bus.
- The UART bus slave pushes bytes into it; it buffers them in a small FIFO and serialises them as 8N1 frames onto the SOC's o_UART_TX pin.
- It decouples CPU store timing from baud timing, so the CPU can issue several byte stores back-to-back without polling per byte.

Parameters:
- CLKS_PER_BIT, 868, i_Clk cycles per serial bit (>=2); 868 gives 115200 baud at 100 MHz.
- FIFO_DEPTH, 8, byte entries; power of two, >=2.
- LEVEL_WIDTH, $clog2(FIFO_DEPTH+1), width of o_Level (derived, not overridden).

Ports:
- i_Clk  in  1  system clock, all logic rising-edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_WrEn  in  1  push strobe, one byte per cycle high.
- i_WrData  in  8  byte to transmit.
- o_Full  out  1  FIFO holds FIFO_DEPTH bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Level  out  LEVEL_WIDTH  current FIFO occupancy.
- o_Busy  out  1  high whenever FSM not IDLE or FIFO non-empty.
- o_Overflow  out  1  sticky; set when a push is dropped, cleared by i_OvfClr.
- i_OvfClr  in  1  clears o_Overflow.
- o_UART_TX  out  1  serial line, idle high, registered output.

Behaviour:
- Reset (async assert, sync-safe deassert by design): o_UART_TX=1, FIFO pointers=0, o_Level=0, o_Empty=1, o_Full=0, o_Busy=0, o_Overflow=0, FSM=IDLE, bit/baud counters=0. Reset mid-frame aborts the frame immediately; line returns high in the same cycle as reset assertion.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally.
  - Level counter is separate; full/empty are derived from the level.
  - Push accepted when i_WrEn && !o_Full.
  - i_WrEn while o_Full drops the byte and sets o_Overflow. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
  - i_OvfClr and an overflow event in the same cycle: set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_UART_TX=1. If FIFO non-empty at an edge, pop head into shift register, load baud counter, go to START; line goes low on that edge.
  - Latency: a byte pushed into an empty FIFO while IDLE at edge k drives the start bit from edge k+1.
  - START: line 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, go to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. At its final cycle, if FIFO non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Baud counter counts CLKS_PER_BIT-1 down to 0.
- The shift register is captured at pop. FIFO contents may change afterwards without affecting the frame in flight.
- o_UART_TX comes straight from a flop, so there are no glitches.

Decomposition:
- Shared package (uart_pkg): FSM state encoding (2-bit enum: IDLE=0, START=1, DATA=2, STOP=3) and constants UART_DATA_BITS=8 and UART_FRAME_BITS=10, reused by the future RX block.
- Sub-module sync_fifo: parameterised DATA_WIDTH/DEPTH, push/pop/full/empty/level, with the same drop-on-full rule. The FSM and baud counter live in uart_tx_engine.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then push 0xA5 once -> start bit low from next cycle. Line samples every 4 cycles are 0,1,0,1,0,0,1,0,1,1. o_Busy falls 40 cycles after start; o_Level returns to 0 one cycle after push.
- Push 0x00,0xFF,0x55 on consecutive cycles -> o_Level peaks at 2. Three frames (120 cycles total) with no idle gap between stop and next start. o_Empty=1 after the third pop.
- Fill to full (5 pushes on consecutive cycles while the first frame starts) -> the 5th byte is accepted only if a pop occurred earlier; otherwise the 6th push asserts o_Overflow. Exactly 4 or 5 frames are transmitted, matching the accepted count. o_Overflow stays 1 until i_OvfClr pulse, then 0.
- Push 0x3C, assert i_Rst for 1 cycle at cycle 15 of the frame -> o_UART_TX=1 immediately; o_Level=0; no further frame is transmitted. A post-reset push of 0x81 transmits cleanly.
- Push with i_WrEn while full and i_OvfClr in the same cycle -> o_Overflow=1 afterwards.
- Push 0x01 when the FIFO is empty and the FSM is in the last STOP cycle of the previous frame -> next start bit follows immediately (back-to-back).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with a separate level counter.
// A push while full is dropped and flagged on o_Drop for that cycle.
module sync_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Push,
  input  logic [DATA_WIDTH-1:0]  i_PushData,
  input  logic                   i_Pop,
  output logic [DATA_WIDTH-1:0]  o_PopData,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [LEVEL_WIDTH-1:0] o_Level,
  output logic                   o_Drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic                   w_push;
  logic                   w_pop;

  assign o_Full    = (r_level == LEVEL_WIDTH'(DEPTH));
  assign o_Empty   = (r_level == '0);
  assign o_Level   = r_level;
  assign o_PopData = r_mem[r_rd_ptr];
  assign w_push    = i_Push && !o_Full;
  assign w_pop     = i_Pop && !o_Empty;
  // Fullness is judged before this cycle's pop, so a same-cycle pop never rescues a push
  assign o_Drop    = i_Push && o_Full;

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_PushData;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LEVEL_WIDTH'(1);
        2'b01:   r_level <= r_level - LEVEL_WIDTH'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit back-end: byte FIFO feeding an 8N1 serialiser with a
// registered TX line; back-to-back frames have no idle gap.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEVEL_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_WrEn,
  input  logic [7:0]             i_WrData,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [LEVEL_WIDTH-1:0] o_Level,
  output logic                   o_Busy,
  output logic                   o_Overflow,
  input  logic                   i_OvfClr,
  output logic                   o_UART_TX
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e       r_state, w_state_nxt;
  logic              r_tx, w_tx_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic              r_ovf;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty;
  logic              w_baud_done;
  logic [7:0]        w_head;

  sync_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (FIFO_DEPTH),
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Push     (i_WrEn),
    .i_PushData (i_WrData),
    .i_Pop      (w_pop),
    .o_PopData  (w_head),
    .o_Full     (o_Full),
    .o_Empty    (w_empty),
    .o_Level    (o_Level),
    .o_Drop     (w_drop)
  );

  assign o_Empty     = w_empty;
  assign o_Busy      = (r_state != ST_IDLE) || !w_empty;
  assign o_Overflow  = r_ovf;
  assign o_UART_TX   = r_tx;
  assign w_baud_done = (r_baud == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = w_baud_done ? r_baud : r_baud - BAUD_W'(1);
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = BAUD_LOAD;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_baud_nxt  = BAUD_LOAD;
          w_tx_nxt    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = BAUD_LOAD;
          if (r_bit == LAST_BIT) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        // Last stop cycle chains straight into the next start bit when data waits
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_baud_nxt  = BAUD_LOAD;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)          r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (i_OvfClr)  r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a transaction-level timeline model
// predicts line level, FIFO occupancy and flags every cycle.
module tb_uart_tx_engine;
  localparam int C = 4;
  localparam int D = 4;
  localparam int LW = $clog2(D + 1);

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b0;
  logic          i_WrEn = 1'b0;
  logic [7:0]    i_WrData = '0;
  logic          i_OvfClr = 1'b0;
  logic          o_Full, o_Empty, o_Busy, o_Overflow, o_UART_TX;
  logic [LW-1:0] o_Level;

  uart_tx_engine #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_WrEn(i_WrEn), .i_WrData(i_WrData),
    .o_Full(o_Full), .o_Empty(o_Empty), .o_Level(o_Level), .o_Busy(o_Busy),
    .o_Overflow(o_Overflow), .i_OvfClr(i_OvfClr), .o_UART_TX(o_UART_TX)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: pending bytes, when the transmitter is next free, current frame.
  logic [7:0] q[$];
  int         cyc = 0;
  int         tx_free_at = 0;
  int         last_start = 0;
  logic [7:0] last_byte = '0;
  bit         have_frame = 0;
  bit         m_ovf = 0;
  int         peak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int t, n;
    if (!have_frame) return 1'b1;
    t = cyc - last_start;
    if (t >= 10 * C) return 1'b1;
    n = t / C;
    if (n == 0) return 1'b0;
    if (n <= 8) return last_byte[n-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    tx_free_at = cyc;
    have_frame = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit clr);
    int  size_before;
    bit  drop;
    size_before = q.size();
    drop = wr && (size_before == D);
    if (size_before > 0 && cyc >= tx_free_at) begin
      last_byte = q.pop_front();
      last_start = cyc;
      have_frame = 1;
      tx_free_at = cyc + 10 * C;
    end
    if (wr && !drop) q.push_back(d);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("tx", 32'(o_UART_TX), 32'(exp_tx()));
    chk("level", 32'(o_Level), 32'(sz));
    chk("empty", 32'(o_Empty), 32'(sz == 0));
    chk("full", 32'(o_Full), 32'(sz == D));
    chk("busy", 32'(o_Busy), 32'((cyc < tx_free_at) || (sz > 0)));
    chk("overflow", 32'(o_Overflow), 32'(m_ovf));
    if (int'(o_Level) > peak) peak = int'(o_Level);
  endtask

  task automatic tick(input bit wr, input logic [7:0] d, input bit clr);
    i_WrEn = wr;
    i_WrData = d;
    i_OvfClr = clr;
    @(posedge i_Clk);
    cyc++;
    model_edge(wr, d, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (q.size() > 0 || cyc < tx_free_at); i++) tick(0, 8'h00, 0);
    idle(2);
  endtask

  task automatic do_reset();
    i_WrEn = 0;
    i_OvfClr = 0;
    i_Rst = 1;
    #1;
    model_reset();
    chk("rst_tx_immediate", 32'(o_UART_TX), 32'd1);
    chk("rst_level_immediate", 32'(o_Level), 32'd0);
    @(posedge i_Clk);
    cyc++;
    model_reset();
    #1;
    i_Rst = 0;
    check_all();
  endtask

  logic [9:0] pat;
  int         s0;

  initial begin
    #2;
    do_reset();
    idle(2);

    // Single byte 0xA5: sample each bit period against the known pattern
    pat = 10'b1101001010;
    tick(1, 8'hA5, 0);
    chk("a5_level_after_push", 32'(o_Level), 32'd1);
    tick(0, 8'h00, 0);
    chk("a5_start_low", 32'(o_UART_TX), 32'd0);
    chk("a5_level_after_pop", 32'(o_Level), 32'd0);
    s0 = cyc;
    for (int i = 1; i < 10; i++) begin
      idle(C);
      chk("a5_bit", 32'(o_UART_TX), 32'(pat[i]));
    end
    while (cyc < s0 + 10 * C - 1) tick(0, 8'h00, 0);
    chk("a5_busy_last_cycle", 32'(o_Busy), 32'd1);
    tick(0, 8'h00, 0);
    chk("a5_busy_fall", 32'(o_Busy), 32'd0);
    idle(3);

    // Three consecutive pushes: peak level 2, frames back-to-back
    peak = 0;
    tick(1, 8'h00, 0);
    tick(1, 8'hFF, 0);
    tick(1, 8'h55, 0);
    chk("peak_level", 32'(peak), 32'd2);
    drain();

    // Fill past full while the first frame starts
    tick(1, 8'h11, 0);
    tick(1, 8'h22, 0);
    tick(1, 8'h33, 0);
    tick(1, 8'h44, 0);
    tick(1, 8'h66, 0);
    tick(1, 8'h77, 0);
    chk("fill_overflow", 32'(o_Overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(o_Overflow), 32'd1);
    tick(0, 8'h00, 1);
    chk("ovf_cleared", 32'(o_Overflow), 32'd0);

    // Reset at cycle 15 of a frame aborts it
    tick(1, 8'h3C, 0);
    tick(1, 8'h99, 0);
    idle(14);
    do_reset();
    idle(50);
    tick(1, 8'h81, 0);
    drain();

    // Overflow set beats clear in the same cycle
    for (int i = 0; i < 5; i++) tick(1, 8'(8'hC0 + i), 0);
    tick(1, 8'hEE, 1);
    chk("ovf_set_wins", 32'(o_Overflow), 32'd1);
    drain();
    tick(0, 8'h00, 1);

    // Push landing in the last stop cycle chains straight into the next frame
    tick(1, 8'h5A, 0);
    while (cyc < tx_free_at - 2) tick(0, 8'h00, 0);
    tick(1, 8'h01, 0);
    tick(0, 8'h00, 0);
    chk("b2b_start", 32'(o_UART_TX), 32'd0);
    drain();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 19) == 0));
      if (i == 300) begin
        i_WrEn = 0;
        i_OvfClr = 0;
        #2;
        do_reset();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
